// File: rtl/tcm_boot_loader_if.sv
// Byte-stream handshake carrying the boot image into the loader.
// A byte transfers on any clock edge where valid and ready are both high.
interface tcm_boot_loader_if;
    logic [7:0] s_byte_data;
    logic       s_byte_valid;
    logic       s_byte_ready;

    modport master (
        output s_byte_data,
        output s_byte_valid,
        input  s_byte_ready
    );

    modport slave (
        input  s_byte_data,
        input  s_byte_valid,
        output s_byte_ready
    );
endinterface

// File: rtl/tcm_boot_loader.sv
// Boot loader: streams a length/image/checksum byte sequence into the TCM and holds the core in reset until it verifies.
// TCM write lands 1 cycle after byte acceptance; 1 byte/cycle. Ready drops once the load ends (DONE or ERR) until rst.
module tcm_boot_loader #(
    parameter  int MEM_WORDS = 4096,
    localparam int ADDR_W    = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    tcm_boot_loader_if.slave  s_byte,
    input  logic              core_mem_we,
    input  logic [ADDR_W-1:0] core_mem_addr,
    input  logic [31:0]       core_mem_wdata,
    input  logic [3:0]        core_mem_be,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              core_rst,
    output logic              done,
    output logic              error
);
    typedef enum logic [2:0] {ST_LEN, ST_DATA, ST_CHK, ST_DONE, ST_ERR} state_t;

    localparam int          CNT_W     = ADDR_W + 2;
    localparam logic [32:0] MAX_BYTES = 33'(MEM_WORDS) << 2;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         len_q, len_d;
    logic [7:0]          sum_q, sum_d;
    logic [23:0]         word_q, word_d;
    logic                ld_we_q, ld_we_d;
    logic [ADDR_W-1:0]   ld_addr_q, ld_addr_d;
    logic [31:0]         ld_wdata_q, ld_wdata_d;
    logic [3:0]          ld_be_q, ld_be_d;

    logic                accept;
    logic [7:0]          byte_in;
    logic [1:0]          lane;
    logic                last;
    logic [31:0]         len_full;
    logic [7:0]          chk_sum;
    logic [31:0]         asm_wdata;
    logic [3:0]          asm_be;

    assign byte_in             = s_byte.s_byte_data;
    assign s_byte.s_byte_ready = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHK);
    assign accept              = s_byte.s_byte_valid && s_byte.s_byte_ready;
    assign lane                = cnt_q[1:0];
    assign len_full            = {byte_in, len_q[23:0]};
    assign chk_sum             = sum_q + byte_in;
    // Counter width covers the largest legal L, so the 32-bit compare is exact.
    assign last                = ({{(32-CNT_W){1'b0}}, cnt_q} == (len_q - 32'd1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        sum_d      = sum_q;
        word_d     = word_q;
        ld_we_d    = 1'b0;
        ld_addr_d  = ld_addr_q;
        ld_wdata_d = ld_wdata_q;
        ld_be_d    = ld_be_q;
        asm_wdata  = 32'h0;
        asm_be     = 4'h0;

        // Unfilled upper lanes are zeroed so stale bytes from the previous word never leak.
        case (lane)
            2'd0: begin asm_wdata = {24'h0, byte_in};              asm_be = 4'b0001; end
            2'd1: begin asm_wdata = {16'h0, byte_in, word_q[7:0]}; asm_be = 4'b0011; end
            2'd2: begin asm_wdata = {8'h0, byte_in, word_q[15:0]}; asm_be = 4'b0111; end
            default: begin asm_wdata = {byte_in, word_q};          asm_be = 4'b1111; end
        endcase

        case (state_q)
            ST_LEN: if (accept) begin
                len_d[8*lane +: 8] = byte_in;
                cnt_d              = cnt_q + CNT_W'(1);
                if (lane == 2'd3) begin
                    cnt_d = '0;
                    if (len_full == 32'h0)                   state_d = ST_CHK;
                    else if ({1'b0, len_full} > MAX_BYTES)   state_d = ST_ERR;
                    else                                     state_d = ST_DATA;
                end
            end
            ST_DATA: if (accept) begin
                sum_d = chk_sum;
                cnt_d = cnt_q + CNT_W'(1);
                case (lane)
                    2'd0:    word_d[7:0]   = byte_in;
                    2'd1:    word_d[15:8]  = byte_in;
                    2'd2:    word_d[23:16] = byte_in;
                    default: word_d        = word_q;
                endcase
                if ((lane == 2'd3) || last) begin
                    ld_we_d    = 1'b1;
                    ld_addr_d  = cnt_q[CNT_W-1:2];
                    ld_wdata_d = asm_wdata;
                    ld_be_d    = asm_be;
                end
                if (last) begin
                    state_d = ST_CHK;
                    cnt_d   = '0;
                end
            end
            ST_CHK: if (accept) begin
                state_d = (chk_sum == 8'h00) ? ST_DONE : ST_ERR;
            end
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_LEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LEN;
            cnt_q      <= '0;
            len_q      <= 32'h0;
            sum_q      <= 8'h0;
            word_q     <= 24'h0;
            ld_we_q    <= 1'b0;
            ld_addr_q  <= '0;
            ld_wdata_q <= 32'h0;
            ld_be_q    <= 4'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            word_q     <= word_d;
            ld_we_q    <= ld_we_d;
            ld_addr_q  <= ld_addr_d;
            ld_wdata_q <= ld_wdata_d;
            ld_be_q    <= ld_be_d;
        end
    end

    assign done     = (state_q == ST_DONE);
    assign error    = (state_q == ST_ERR);
    assign core_rst = !done;

    // Once booted the core owns the TCM port outright.
    assign mem_we    = done ? core_mem_we    : ld_we_q;
    assign mem_addr  = done ? core_mem_addr  : ld_addr_q;
    assign mem_wdata = done ? core_mem_wdata : ld_wdata_q;
    assign mem_be    = done ? core_mem_be    : ld_be_q;
endmodule

// File: tb/tb_tcm_boot_loader.sv
// Directed bench for tcm_boot_loader with a 16-word TCM; checks writes, status and port handover.
module tb_tcm_boot_loader;
    localparam int MW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_mem_we;
    logic [AW-1:0] core_mem_addr;
    logic [31:0]   core_mem_wdata;
    logic [3:0]    core_mem_be;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          core_rst, done, error;

    always #5 clk = ~clk;

    tcm_boot_loader_if bif ();

    tcm_boot_loader #(.MEM_WORDS(MW)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .s_byte         (bif),
        .core_mem_we    (core_mem_we),
        .core_mem_addr  (core_mem_addr),
        .core_mem_wdata (core_mem_wdata),
        .core_mem_be    (core_mem_be),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_be         (mem_be),
        .core_rst       (core_rst),
        .done           (done),
        .error          (error)
    );

    int            vectors    = 0;
    int            miscompares = 0;
    logic [7:0]    stream[$];
    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    logic [3:0]    wr_be[$];
    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];
    logic [3:0]    exp_be[$];

    // Loader-side write log; core pass-through traffic after done is checked directly.
    always @(negedge clk) begin
        if (mem_we === 1'b1 && done !== 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            wr_be.push_back(mem_be);
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete(); wr_data.delete(); wr_be.delete();
        exp_addr.delete(); exp_data.delete(); exp_be.delete();
    endtask

    task automatic do_reset();
        bif.s_byte_valid = 1'b0;
        bif.s_byte_data  = 8'h00;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_log();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bif.s_byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bif.s_byte_data  = b;
        bif.s_byte_valid = 1'b1;
        for (int n = 0; n < 20 && bif.s_byte_ready !== 1'b1; n++) @(negedge clk);
        check("byte_ready", 32'(bif.s_byte_ready), 32'd1);
        @(negedge clk);
        bif.s_byte_valid = 1'b0;
    endtask

    task automatic send_stream(input int maxgap);
        for (int i = 0; i < stream.size(); i++)
            send_byte(stream[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
        exp_addr.push_back(a); exp_data.push_back(d); exp_be.push_back(b);
    endtask

    task automatic compare_writes(input string tag);
        @(negedge clk);
        check($sformatf("%s_wr_count", tag), 32'(wr_data.size()), 32'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < wr_data.size(); i++) begin
            check($sformatf("%s_w%0d_addr", tag, i), 32'(wr_addr[i]), 32'(exp_addr[i]));
            check($sformatf("%s_w%0d_data", tag, i), wr_data[i], exp_data[i]);
            check($sformatf("%s_w%0d_be", tag, i), 32'(wr_be[i]), 32'(exp_be[i]));
        end
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic cr, input logic rdy);
        check({tag, "_done"}, 32'(done), 32'(d));
        check({tag, "_error"}, 32'(error), 32'(e));
        check({tag, "_core_rst"}, 32'(core_rst), 32'(cr));
        check({tag, "_ready"}, 32'(bif.s_byte_ready), 32'(rdy));
    endtask

    task automatic drive_core(input logic we);
        core_mem_we    = we;
        core_mem_addr  = 4'd3;
        core_mem_wdata = 32'hDEADBEEF;
        core_mem_be    = 4'hC;
    endtask

    initial begin
        drive_core(1'b0);
        bif.s_byte_valid = 1'b0;
        bif.s_byte_data  = 8'h00;

        // Reset state
        do_reset();
        check_status("rst", 1'b0, 1'b0, 1'b1, 1'b1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);

        // 1: L=8, two full words; word 0 visible the cycle after byte 0x44
        stream = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                   8'h55, 8'h66, 8'h77, 8'h88, 8'h9C};
        for (int i = 0; i < stream.size(); i++) begin
            send_byte(stream[i], 0);
            if (i == 7) begin
                check("s1_lat_we", 32'(mem_we), 32'd1);
                check("s1_lat_data", mem_wdata, 32'h44332211);
            end
        end
        expect_wr(4'd0, 32'h44332211, 4'hF);
        expect_wr(4'd1, 32'h88776655, 4'hF);
        check_status("s1", 1'b1, 1'b0, 1'b0, 1'b0);
        compare_writes("s1");

        // 2: L=5, partial final word
        do_reset();
        stream = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hF1};
        send_stream(0);
        expect_wr(4'd0, 32'h04030201, 4'hF);
        expect_wr(4'd1, 32'h00000005, 4'h1);
        check_status("s2", 1'b1, 1'b0, 1'b0, 1'b0);
        compare_writes("s2");

        // 6: after done the core owns the port combinationally
        drive_core(1'b1);
        #1;
        check("s6_pass_we", 32'(mem_we), 32'd1);
        check("s6_pass_addr", 32'(mem_addr), 32'd3);
        check("s6_pass_wdata", mem_wdata, 32'hDEADBEEF);
        check("s6_pass_be", 32'(mem_be), 32'hC);
        drive_core(1'b0);
        #1;
        check("s6_pass_we_low", 32'(mem_we), 32'd0);

        // 6 (pre-done) then 3: bad checksum
        do_reset();
        drive_core(1'b1);
        #1;
        check("s6_pre_we", 32'(mem_we), 32'd0);
        check("s6_pre_addr", 32'(mem_addr), 32'd0);
        drive_core(1'b0);
        stream = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                   8'h55, 8'h66, 8'h77, 8'h88, 8'h9D};
        send_stream(0);
        expect_wr(4'd0, 32'h44332211, 4'hF);
        expect_wr(4'd1, 32'h88776655, 4'hF);
        check_status("s3", 1'b0, 1'b1, 1'b1, 1'b0);
        compare_writes("s3");
        drive_core(1'b1);
        #1;
        check("s3_core_blocked", 32'(mem_we), 32'd0);
        drive_core(1'b0);

        // 4: oversize length errors right after the header
        do_reset();
        stream = '{8'h41, 8'h00, 8'h00, 8'h00};
        send_stream(0);
        check_status("s4_big", 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        compare_writes("s4_big");

        // 4: empty image
        do_reset();
        stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_stream(0);
        check_status("s4_zero", 1'b1, 1'b0, 1'b0, 1'b0);
        compare_writes("s4_zero");

        // Max length fills every word: bytes 0..63, sum 0xE0, checksum 0x20
        do_reset();
        stream = '{8'h40, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 64; i++) stream.push_back(8'(i));
        stream.push_back(8'h20);
        send_stream(0);
        for (int w = 0; w < 16; w++)
            expect_wr(4'(w), {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, 4'hF);
        check_status("smax", 1'b1, 1'b0, 1'b0, 1'b0);
        compare_writes("smax");

        // 5: gapped stream aborted by rst after payload byte 6, then resent
        do_reset();
        stream = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_stream(5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_status("s5_rst", 1'b0, 1'b0, 1'b1, 1'b1);
        stream = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                   8'h55, 8'h66, 8'h77, 8'h88, 8'h9C};
        send_stream(5);
        expect_wr(4'd0, 32'h44332211, 4'hF);
        expect_wr(4'd0, 32'h44332211, 4'hF);
        expect_wr(4'd1, 32'h88776655, 4'hF);
        check_status("s5", 1'b1, 1'b0, 1'b0, 1'b0);
        compare_writes("s5");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
